// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared cpu definitions for the instruction fetch stage
//
// Purpose: jump opcode, bubble word default, fetch FSM state encoding and the
//          prioritised fetch-event type used by fetch_unit.
// Ports:   none (package).
package fetch_unit_pkg;

  localparam logic [5:0]  OP_J             = 6'b000010;
  localparam logic [31:0] NOP_WORD_DEFAULT = 32'd0;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_REDIRECT = 2'd2
  } fetch_state_e;

  // Highest-priority event seen by a fetching (RUN/REDIRECT) cycle.
  typedef enum logic [2:0] {
    EV_DISABLE = 3'd0,
    EV_BRANCH  = 3'd1,
    EV_STALL   = 3'd2,
    EV_JUMP    = 3'd3,
    EV_SEQ     = 3'd4
  } fetch_event_e;

  // An X opcode yields X here, which the event decode treats as "not a jump",
  // so undefined words flow through as ordinary instructions.
  function automatic logic is_jump(input logic [31:0] instr);
    return instr[31:26] == OP_J;
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - fetch stage control, instruction memory and IF/ID bundle
//
// Purpose: groups every non-clock/reset signal of fetch_unit.
// Ports (master = fetch_unit side):
//   in : if_enable, if_stall, if_flush, if_branch_taken, if_branch_target[31:0],
//        imem_instruction[31:0]
//   out: imem_pc[31:0], if_instruction[31:0], if_pc_plus4[31:0], if_valid,
//        if_state[1:0]
interface fetch_unit_if;
  import fetch_unit_pkg::*;

  logic         if_enable;
  logic         if_stall;
  logic         if_flush;
  logic         if_branch_taken;
  logic [31:0]  if_branch_target;
  logic [31:0]  imem_pc;
  logic [31:0]  imem_instruction;
  logic [31:0]  if_instruction;
  logic [31:0]  if_pc_plus4;
  logic         if_valid;
  fetch_state_e if_state;

  modport master (
    input  if_enable, if_stall, if_flush, if_branch_taken, if_branch_target,
    input  imem_instruction,
    output imem_pc, if_instruction, if_pc_plus4, if_valid, if_state
  );

  modport slave (
    output if_enable, if_stall, if_flush, if_branch_taken, if_branch_target,
    output imem_instruction,
    input  imem_pc, if_instruction, if_pc_plus4, if_valid, if_state
  );

endinterface

// File: rtl/fetch_unit_if_id_reg.sv
// rtl/fetch_unit_if_id_reg.sv - IF/ID pipeline register with load, bubble and hold
//
// Purpose: holds the fetched instruction word, its address + 4 and a valid bit.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   i_hold            : keep current contents (highest priority after reset)
//   i_bubble          : load NOP_WORD with valid cleared
//   i_load            : load i_instruction / i_pc_plus4 with valid set
//   i_instruction     : fetched word
//   i_pc_plus4        : fetch address + 4
//   o_instruction, o_pc_plus4, o_valid : registered IF/ID contents
module if_id_reg
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] NOP_WORD = NOP_WORD_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_hold,
  input  logic        i_bubble,
  input  logic        i_load,
  input  logic [31:0] i_instruction,
  input  logic [31:0] i_pc_plus4,
  output logic [31:0] o_instruction,
  output logic [31:0] o_pc_plus4,
  output logic        o_valid
);

  logic [31:0] r_instruction;
  logic [31:0] r_pc_plus4;
  logic        r_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_instruction <= NOP_WORD;
      r_pc_plus4    <= 32'd0;
      r_valid       <= 1'b0;
    end else if (i_hold) begin
      r_instruction <= r_instruction;
      r_pc_plus4    <= r_pc_plus4;
      r_valid       <= r_valid;
    end else if (i_bubble) begin
      r_instruction <= NOP_WORD;
      r_pc_plus4    <= 32'd0;
      r_valid       <= 1'b0;
    end else if (i_load) begin
      r_instruction <= i_instruction;
      r_pc_plus4    <= i_pc_plus4;
      r_valid       <= 1'b1;
    end
  end

  assign o_instruction = r_instruction;
  assign o_pc_plus4    = r_pc_plus4;
  assign o_valid       = r_valid;

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage with in-fetch jump resolution
//
// Purpose: PC register driving instruction memory directly, three-state fetch
//          FSM (IDLE/RUN/REDIRECT), jump decode and target adder, IF/ID register.
// Parameters:
//   RESET_PC : first instruction byte address
//   NOP_WORD : instruction word loaded into IF/ID for a bubble
// Ports:
//   clk  : clock, all state on rising edge
//   rst  : synchronous active-high reset
//   bus  : fetch_unit_if.master (controls in, imem_pc/imem_instruction, IF/ID out)
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'd4,
  parameter logic [31:0] NOP_WORD = NOP_WORD_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  fetch_unit_if.master  bus
);

  logic [31:0]  r_pc;
  fetch_state_e r_state;
  fetch_state_e w_state_next;
  fetch_event_e w_event;

  logic [31:0]  w_pc_next;
  logic         w_ifid_hold;
  logic         w_ifid_bubble;
  logic         w_ifid_load;

  logic [31:0]  w_pc_plus4;
  logic [31:0]  w_jump_offset;
  logic [31:0]  w_jump_target;
  logic [31:0]  w_branch_target;

  // Address arithmetic wraps modulo 2^32 by construction of the 32-bit adders.
  assign w_pc_plus4      = r_pc + 32'd4;
  assign w_jump_offset   = {{4{bus.imem_instruction[25]}}, bus.imem_instruction[25:0], 2'b00};
  assign w_jump_target   = w_pc_plus4 + w_jump_offset;
  assign w_branch_target = bus.if_branch_target & ~32'd3;

  // Priority: disable, taken branch, stall, jump, sequential.
  always_comb begin
    w_event = EV_SEQ;
    if (!bus.if_enable) begin
      w_event = EV_DISABLE;
    end else if (bus.if_branch_taken) begin
      w_event = EV_BRANCH;
    end else if (bus.if_stall) begin
      w_event = EV_STALL;
    end else if (is_jump(bus.imem_instruction)) begin
      w_event = EV_JUMP;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next state. REDIRECT fetches exactly like RUN; it only marks the
  // bubble cycle after a redirect and falls back to RUN unless redirected again.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        w_state_next = bus.if_enable ? ST_RUN : ST_IDLE;
      end
      ST_RUN, ST_REDIRECT: begin
        case (w_event)
          EV_DISABLE:        w_state_next = ST_IDLE;
          EV_BRANCH, EV_JUMP: w_state_next = ST_REDIRECT;
          EV_STALL, EV_SEQ:  w_state_next = ST_RUN;
          default:           w_state_next = ST_IDLE;
        endcase
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // FSM outputs: next PC and IF/ID control.
  always_comb begin
    w_pc_next     = r_pc;
    w_ifid_hold   = 1'b0;
    w_ifid_bubble = 1'b0;
    w_ifid_load   = 1'b0;
    case (r_state)
      ST_RUN, ST_REDIRECT: begin
        case (w_event)
          EV_DISABLE: begin
            w_ifid_bubble = 1'b1;
          end
          EV_BRANCH: begin
            w_pc_next     = w_branch_target;
            w_ifid_bubble = 1'b1;
          end
          EV_STALL: begin
            w_ifid_hold = 1'b1;
          end
          EV_JUMP: begin
            // The jump word itself is consumed here and never reaches decode.
            w_pc_next     = w_jump_target;
            w_ifid_bubble = 1'b1;
          end
          EV_SEQ: begin
            w_pc_next = w_pc_plus4;
            // A flush squashes only the IF/ID load; the PC still advances.
            if (bus.if_flush) begin
              w_ifid_bubble = 1'b1;
            end else begin
              w_ifid_load = 1'b1;
            end
          end
          default: begin
            w_ifid_bubble = 1'b1;
          end
        endcase
      end
      default: begin
        w_ifid_bubble = 1'b1;
      end
    endcase
  end

  // PC register; the low two bits are forced to zero on every write.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc <= RESET_PC & ~32'd3;
    end else begin
      r_pc <= w_pc_next & ~32'd3;
    end
  end

  if_id_reg #(
    .NOP_WORD (NOP_WORD)
  ) u_if_id_reg (
    .clk           (clk),
    .rst           (rst),
    .i_hold        (w_ifid_hold),
    .i_bubble      (w_ifid_bubble),
    .i_load        (w_ifid_load),
    .i_instruction (bus.imem_instruction),
    .i_pc_plus4    (w_pc_plus4),
    .o_instruction (bus.if_instruction),
    .o_pc_plus4    (bus.if_pc_plus4),
    .o_valid       (bus.if_valid)
  );

  assign bus.imem_pc  = r_pc;
  assign bus.if_state = r_state;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard bench for fetch_unit
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  localparam logic [31:0] TB_NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [1:0]  st;
    logic        v;
    logic [31:0] ins;
    logic [31:0] p4;
  } exp_t;

  typedef struct packed {
    logic        r;
    logic        en;
    logic        stall;
    logic        flush;
    logic        br;
    logic [31:0] tgt;
  } stim_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_unit_if bus();

  fetch_unit #(
    .RESET_PC (32'd4),
    .NOP_WORD (TB_NOP)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Instruction memory: j -35 at 140, beq at 120, otherwise a non-jump word
  // that encodes its own address so misrouted fetches are visible.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'd140: return 32'h0BFF_FFDD;
      32'd120: return 32'h10A0_0005;
      default: return {6'b001000, a[25:0]};
    endcase
  endfunction

  assign bus.imem_instruction = mem_word(bus.imem_pc);

  int    checks   = 0;
  int    failures = 0;
  exp_t  sb[$];
  stim_t sq[$];
  logic [31:0] epc;

  function automatic stim_t mk_s(input logic r, en, st, fl, br, input logic [31:0] tgt);
    stim_t s;
    s.r = r; s.en = en; s.stall = st; s.flush = fl; s.br = br; s.tgt = tgt;
    return s;
  endfunction

  function automatic exp_t mk_e(input logic [31:0] pc, input logic [1:0] st, input logic v,
                                input logic [31:0] ins, input logic [31:0] p4);
    exp_t e;
    e.pc = pc; e.st = st; e.v = v; e.ins = ins; e.p4 = p4;
    return e;
  endfunction

  // Expected result of one sequential fetch from address a.
  function automatic exp_t run_exp(input logic [31:0] a);
    logic [31:0] n;
    n = a + 32'd4;
    return mk_e(n, 2'd1, 1'b1, mem_word(a), n);
  endfunction

  function automatic exp_t bubble(input logic [31:0] pc, input logic [1:0] st);
    return mk_e(pc, st, 1'b0, TB_NOP, 32'd0);
  endfunction

  // pc_plus4 is only meaningful while IF/ID holds a valid instruction.
  function automatic exp_t observe();
    exp_t o;
    o.pc  = bus.imem_pc;
    o.st  = bus.if_state;
    o.v   = bus.if_valid;
    o.ins = bus.if_instruction;
    o.p4  = bus.if_valid ? bus.if_pc_plus4 : 32'd0;
    return o;
  endfunction

  task automatic plan(input stim_t s, input exp_t e);
    sq.push_back(s);
    sb.push_back(e);
  endtask

  task automatic plan_run_to(input logic [31:0] target);
    for (int n = 0; n < 1000 && epc != target; n++) begin
      plan(mk_s(0, 1, 0, 0, 0, 32'd0), run_exp(epc));
      epc = epc + 32'd4;
    end
  endtask

  task automatic drive(input stim_t s);
    rst                  = s.r;
    bus.if_enable        = s.en;
    bus.if_stall         = s.stall;
    bus.if_flush         = s.flush;
    bus.if_branch_taken  = s.br;
    bus.if_branch_target = s.tgt;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    stim_t s;
    exp_t  e;
    exp_t  o;
    int    i;
    // Reset wins over every other input.
    plan(mk_s(1, 1, 1, 1, 1, 32'd200), bubble(32'd4, 2'd0));
    plan(mk_s(1, 0, 0, 0, 0, 32'd0),   bubble(32'd4, 2'd0));
    i = 0;
    while (sq.size() > 0) begin
      s = sq.pop_front();
      drive(s);
      e = sb.pop_front();
      o = observe();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL reset[%0d] got pc=%h st=%0d v=%b ins=%h p4=%h exp pc=%h st=%0d v=%b ins=%h p4=%h",
                 i, o.pc, o.st, o.v, o.ins, o.p4, e.pc, e.st, e.v, e.ins, e.p4);
      end
      i++;
    end
    checks++;
    if (bus.if_pc_plus4 !== 32'd0) begin
      failures++;
      $display("FAIL reset_pc_plus4 got=%h exp=%h", bus.if_pc_plus4, 32'd0);
    end
  endtask

  task automatic test_sequential();
    stim_t s;
    exp_t  e;
    exp_t  o;
    int    i;
    plan(mk_s(0, 1, 0, 0, 0, 32'd0), bubble(32'd4, 2'd1));
    epc = 32'd4;
    plan_run_to(32'd16);
    i = 0;
    while (sq.size() > 0) begin
      s = sq.pop_front();
      drive(s);
      e = sb.pop_front();
      o = observe();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL seq[%0d] got pc=%h st=%0d v=%b ins=%h p4=%h exp pc=%h st=%0d v=%b ins=%h p4=%h",
                 i, o.pc, o.st, o.v, o.ins, o.p4, e.pc, e.st, e.v, e.ins, e.p4);
      end
      i++;
    end
  endtask

  task automatic test_jump();
    stim_t s;
    exp_t  e;
    exp_t  o;
    int    i;
    plan_run_to(32'd140);
    // j -35 at 140: target 144 - 140 = 4, one bubble, REDIRECT.
    plan(mk_s(0, 1, 0, 0, 0, 32'd0), bubble(32'd4, 2'd2));
    plan(mk_s(0, 1, 0, 0, 0, 32'd0), run_exp(32'd4));
    epc = 32'd8;
    i = 0;
    while (sq.size() > 0) begin
      s = sq.pop_front();
      drive(s);
      e = sb.pop_front();
      o = observe();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL jump[%0d] got pc=%h st=%0d v=%b ins=%h p4=%h exp pc=%h st=%0d v=%b ins=%h p4=%h",
                 i, o.pc, o.st, o.v, o.ins, o.p4, e.pc, e.st, e.v, e.ins, e.p4);
      end
      i++;
    end
  endtask

  task automatic test_branch_stall();
    stim_t s;
    exp_t  e;
    exp_t  o;
    int    i;
    plan_run_to(32'd120);
    // Branch with unaligned target and a simultaneous stall: branch wins.
    plan(mk_s(0, 1, 1, 0, 1, 32'd143), bubble(32'd140, 2'd2));
    // Jump fetched while in REDIRECT re-enters REDIRECT.
    plan(mk_s(0, 1, 0, 0, 0, 32'd0),   bubble(32'd4, 2'd2));
    plan(mk_s(0, 1, 0, 0, 0, 32'd0),   run_exp(32'd4));
    epc = 32'd8;
    i = 0;
    while (sq.size() > 0) begin
      s = sq.pop_front();
      drive(s);
      e = sb.pop_front();
      o = observe();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL branch[%0d] got pc=%h st=%0d v=%b ins=%h p4=%h exp pc=%h st=%0d v=%b ins=%h p4=%h",
                 i, o.pc, o.st, o.v, o.ins, o.p4, e.pc, e.st, e.v, e.ins, e.p4);
      end
      i++;
    end
  endtask

  task automatic test_stall();
    stim_t s;
    exp_t  e;
    exp_t  o;
    int    i;
    plan_run_to(32'd24);
    for (int k = 0; k < 3; k++) begin
      plan(mk_s(0, 1, 1, 0, 0, 32'd0), mk_e(32'd24, 2'd1, 1'b1, mem_word(32'd20), 32'd24));
    end
    plan(mk_s(0, 1, 0, 0, 0, 32'd0), run_exp(32'd24));
    epc = 32'd28;
    i = 0;
    while (sq.size() > 0) begin
      s = sq.pop_front();
      drive(s);
      e = sb.pop_front();
      o = observe();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL stall[%0d] got pc=%h st=%0d v=%b ins=%h p4=%h exp pc=%h st=%0d v=%b ins=%h p4=%h",
                 i, o.pc, o.st, o.v, o.ins, o.p4, e.pc, e.st, e.v, e.ins, e.p4);
      end
      i++;
    end
  endtask

  task automatic test_flush_wrap();
    stim_t s;
    exp_t  e;
    exp_t  o;
    int    i;
    plan_run_to(32'd48);
    plan(mk_s(0, 1, 0, 1, 0, 32'd0), bubble(32'd52, 2'd1));
    plan(mk_s(0, 1, 0, 0, 0, 32'd0), run_exp(32'd52));
    plan(mk_s(0, 1, 0, 0, 1, 32'hFFFF_FFFC), bubble(32'hFFFF_FFFC, 2'd2));
    plan(mk_s(0, 1, 0, 0, 0, 32'd0), run_exp(32'hFFFF_FFFC));
    plan(mk_s(0, 1, 0, 0, 0, 32'd0), run_exp(32'd0));
    epc = 32'd8;
    i = 0;
    while (sq.size() > 0) begin
      s = sq.pop_front();
      drive(s);
      e = sb.pop_front();
      o = observe();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL flush_wrap[%0d] got pc=%h st=%0d v=%b ins=%h p4=%h exp pc=%h st=%0d v=%b ins=%h p4=%h",
                 i, o.pc, o.st, o.v, o.ins, o.p4, e.pc, e.st, e.v, e.ins, e.p4);
      end
      i++;
    end
  endtask

  task automatic test_reset_redirect_disable();
    stim_t s;
    exp_t  e;
    exp_t  o;
    int    i;
    plan(mk_s(0, 1, 0, 0, 1, 32'd100), bubble(32'd100, 2'd2));
    plan(mk_s(1, 1, 0, 0, 0, 32'd0),   bubble(32'd4, 2'd0));
    plan(mk_s(0, 1, 0, 0, 0, 32'd0),   bubble(32'd4, 2'd1));
    plan(mk_s(0, 1, 0, 0, 0, 32'd0),   run_exp(32'd4));
    plan(mk_s(0, 0, 0, 0, 0, 32'd0),   bubble(32'd8, 2'd0));
    plan(mk_s(0, 0, 0, 0, 0, 32'd0),   bubble(32'd8, 2'd0));
    i = 0;
    while (sq.size() > 0) begin
      s = sq.pop_front();
      drive(s);
      e = sb.pop_front();
      o = observe();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL rst_dis[%0d] got pc=%h st=%0d v=%b ins=%h p4=%h exp pc=%h st=%0d v=%b ins=%h p4=%h",
                 i, o.pc, o.st, o.v, o.ins, o.p4, e.pc, e.st, e.v, e.ins, e.p4);
      end
      i++;
    end
  endtask

  initial begin
    rst                  = 1'b1;
    bus.if_enable        = 1'b0;
    bus.if_stall         = 1'b0;
    bus.if_flush         = 1'b0;
    bus.if_branch_taken  = 1'b0;
    bus.if_branch_target = 32'd0;
    epc                  = 32'd4;
    test_reset();
    test_sequential();
    test_jump();
    test_branch_stall();
    test_stall();
    test_flush_wrap();
    test_reset_redirect_disable();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
